// File: rtl/cic_int_sched_if.sv
// Bundle of the scheduler's configuration, upstream stream and interpolator-side signals.
// The master modport is the scheduler. The slave modport is the surrounding SoC or the bench.
// Widths must agree with the scheduler instance: RW = $clog2(RMAX+1).
interface cic_int_sched_if #(
  parameter int I_WIDTH = 16,
  parameter int RW      = 11,
  parameter int UCNT_W  = 16
);
  logic               cfg_enable;
  logic [RW-1:0]      cfg_rate;
  logic               cfg_rate_wr;
  logic               cfg_cnt_clr;
  logic [I_WIDTH-1:0] s_tdata;
  logic               s_tvalid;
  logic               s_tready;
  logic [I_WIDTH-1:0] cic_tdata;
  logic               cic_rst;
  logic               cic_ce;
  logic               sample_stb;
  logic [RW-1:0]      rate;
  logic               cfg_err;
  logic [UCNT_W-1:0]  underrun_cnt;
  logic               busy;

  modport master (
    input  cfg_enable, cfg_rate, cfg_rate_wr, cfg_cnt_clr, s_tdata, s_tvalid,
    output s_tready, cic_tdata, cic_rst, cic_ce, sample_stb, rate, cfg_err,
           underrun_cnt, busy
  );

  modport slave (
    output cfg_enable, cfg_rate, cfg_rate_wr, cfg_cnt_clr, s_tdata, s_tvalid,
    input  s_tready, cic_tdata, cic_rst, cic_ce, sample_stb, rate, cfg_err,
           underrun_cnt, busy
  );
endinterface

// File: rtl/cic_int_sched.sv
// CIC interpolator sample scheduler: one upstream sample per rate-cycle slot, held on cic_tdata.
// Latency: slot to cic_tdata/sample_stb is 1 cycle; flush lasts FLUSH_CYC cycles before RUN.
// Backpressure: s_tready only in the registered slot cycle; CIC_SCHED_HOLD_LAST_EN keeps the last sample on underrun.
module cic_int_sched #(
  parameter int I_WIDTH   = 16,
  parameter int RMAX      = 1625,
  parameter int N         = 5,
  parameter int FLUSH_CYC = N + 2,
  parameter int UCNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  cic_int_sched_if.master bus
);
  localparam int RW = $clog2(RMAX + 1);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FW-1:0]      flush_cnt_q;
  logic [RW-1:0]      phase_q;
  logic [RW-1:0]      rate_q;
  logic [I_WIDTH-1:0] data_q;
  logic               stb_q;
  logic               err_q;
  logic [UCNT_W-1:0]  ucnt_q;

  logic rate_ok;
  logic rate_wr_ok;
  logic flush_enter;
  logic flush_done;
  logic slot;
  logic underrun;

  assign rate_ok    = (bus.cfg_rate != '0) && (bus.cfg_rate <= RW'(RMAX));
  assign rate_wr_ok = bus.cfg_rate_wr && rate_ok;
  assign flush_done = (flush_cnt_q == FW'(FLUSH_CYC - 1));
  // A slot that the upstream leaves empty is still consumed as an underrun.
  assign slot       = (state_q == ST_RUN) && (phase_q == '0);
  assign underrun   = slot && !bus.s_tvalid;

  // Next state: disable wins, then a legal rate write restarts the flush, then normal sequencing.
  always_comb begin
    state_d     = state_q;
    flush_enter = 1'b0;
    if (!bus.cfg_enable) begin
      state_d = ST_IDLE;
    end else if (rate_wr_ok && (state_q != ST_IDLE)) begin
      state_d     = ST_FLUSH;
      flush_enter = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_FLUSH;
          flush_enter = 1'b1;
        end
        ST_FLUSH: if (flush_done) state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Flush length counter, restarted on every flush entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     flush_cnt_q <= '0;
    else if (flush_enter)                        flush_cnt_q <= '0;
    else if ((state_q == ST_FLUSH) && !flush_done) flush_cnt_q <= flush_cnt_q + FW'(1);
  end

  // Slot phase: 0..rate-1 in RUN, zeroed on flush entry so RUN opens with a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    phase_q <= '0;
    else if (flush_enter)       phase_q <= '0;
    else if (state_q == ST_RUN) phase_q <= (phase_q >= rate_q - RW'(1)) ? '0 : phase_q + RW'(1);
  end

  // Active ratio and rejected-write pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rate_q <= RW'(RMAX);
      err_q  <= 1'b0;
    end else begin
      if (rate_wr_ok) rate_q <= bus.cfg_rate;
      err_q <= bus.cfg_rate_wr && !rate_ok;
    end
  end

  // Held sample: cleared on flush entry, otherwise updated once per slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      stb_q  <= 1'b0;
    end else begin
      stb_q <= slot;
      if (flush_enter) begin
        data_q <= '0;
      end else if (slot) begin
        if (bus.s_tvalid) data_q <= bus.s_tdata;
`ifdef CIC_SCHED_HOLD_LAST_EN
        else              data_q <= data_q;
`else
        else              data_q <= '0;
`endif
      end
    end
  end

  // Saturating underrun counter; a clear coinciding with an underrun leaves one count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          ucnt_q <= '0;
    else if (bus.cfg_cnt_clr)         ucnt_q <= underrun ? UCNT_W'(1) : '0;
    else if (underrun && !(&ucnt_q))  ucnt_q <= ucnt_q + UCNT_W'(1);
  end

  assign bus.s_tready     = slot;
  assign bus.cic_tdata    = data_q;
  assign bus.cic_rst      = (state_q != ST_RUN);
  assign bus.cic_ce       = (state_q == ST_RUN);
  assign bus.sample_stb   = stb_q;
  assign bus.rate         = rate_q;
  assign bus.cfg_err      = err_q;
  assign bus.underrun_cnt = ucnt_q;
  assign bus.busy         = (state_q == ST_FLUSH);
endmodule
